// File: rtl/spi_pkg.sv
// Shared types and constants for the configurable SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } spi_state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK generator: CLKDIV-cycle tick counter, SCLK level and leading/trailing edge strobes.
module spi_clkgen import spi_pkg::*; #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclk_en,
  input  logic cpol,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int unsigned CW = clog2(CLKDIV);
  localparam logic [CW-1:0] CntMax = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  always_comb begin
    tick   = en && (cnt_q == CntMax);
    lead   = tick && sclk_en && (sclk_q == cpol);
    trail  = tick && sclk_en && (sclk_q != cpol);
    cnt_d  = (!en || tick) ? '0 : cnt_q + CW'(1);
    // Outside SHIFT the clock rests at the polarity level
    sclk_d = sclk_en ? (sclk_q ^ tick) : cpol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master: one word per bus write, all four modes, one-hot slave select.
module spi_master_cfg import spi_pkg::*; #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned NSS       = 1,
  parameter int unsigned CLKDIV    = 2,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DWIDTH-1:0]     din,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [clog2(NSS)-1:0] ss_sel,
  output logic [DWIDTH-1:0]     dout,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sclk,
  output logic [NSS-1:0]        ss_n,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SSW = clog2(NSS);
  localparam int unsigned ECW = clog2(2 * DWIDTH + 1);
  localparam logic [ECW-1:0] LastEdge = ECW'(2 * DWIDTH - 1);

  spi_state_e        state_q, state_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [SSW-1:0]    sel_q, sel_d;
  logic [DWIDTH-1:0] tx_q, rx_q, dout_q;
  logic [ECW-1:0]    edge_q;
  logic              mosi_q, done_q, done_d, busy_q, busy_d;
  logic [NSS-1:0]    ss_n_q, ss_n_d;
  logic              wr_acc, tick, lead, trail, clk_en, sclk_en, upd, smp;

  function automatic logic out_bit(input logic [DWIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[DWIDTH-1];
  endfunction

  function automatic logic [DWIDTH-1:0] shift_out(input logic [DWIDTH-1:0] w);
    return LSB_FIRST ? {1'b0, w[DWIDTH-1:1]} : {w[DWIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DWIDTH-1:0] shift_in(input logic [DWIDTH-1:0] w, input logic b);
    return LSB_FIRST ? {b, w[DWIDTH-1:1]} : {w[DWIDTH-2:0], b};
  endfunction

  always_comb begin
    wr_acc = cs && wr && !rd && (state_q == StIdle);
    cpol_d = wr_acc ? cpol   : cpol_q;
    cpha_d = wr_acc ? cpha   : cpha_q;
    sel_d  = wr_acc ? ss_sel : sel_q;
    upd    = cpha_q ? lead  : trail;
    smp    = cpha_q ? trail : lead;
  end

  // cpol_d lets sclk move to the new idle level on the accepting edge itself
  spi_clkgen #(
    .CLKDIV (CLKDIV)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .en      (clk_en),
    .sclk_en (sclk_en),
    .cpol    (cpol_d),
    .tick    (tick),
    .lead    (lead),
    .trail   (trail),
    .sclk    (sclk)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (wr_acc) state_d = StSetup;
      StSetup: if (tick) state_d = StShift;
      StShift: if (tick && (edge_q == LastEdge)) state_d = StHold;
      StHold:  if (tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clk_en  = (state_q != StIdle);
    sclk_en = (state_q == StShift);
    busy_d  = (state_d != StIdle);
    done_d  = (state_q == StHold) && (state_d == StIdle);
    ss_n_d  = '1;
    if (state_d != StIdle) ss_n_d = ~(NSS'(1) << sel_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      sel_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      dout_q <= '0;
      edge_q <= '0;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      ss_n_q <= '1;
    end else begin
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      sel_q  <= sel_d;
      done_q <= done_d;
      busy_q <= busy_d;
      ss_n_q <= ss_n_d;
      if (wr_acc) begin
        edge_q <= '0;
        rx_q   <= '0;
        // CPHA=0 presents the first bit during SETUP; CPHA=1 waits for the first leading edge
        tx_q   <= cpha ? din : shift_out(din);
        if (!cpha) mosi_q <= out_bit(din);
      end else begin
        if (lead || trail) edge_q <= edge_q + ECW'(1);
        if (upd) begin
          mosi_q <= out_bit(tx_q);
          tx_q   <= shift_out(tx_q);
        end
        if (smp) rx_q <= shift_in(rx_q, miso);
      end
      if (done_d) dout_q <= rx_q;
    end
  end

  assign dout = dout_q;
  assign mosi = mosi_q;
  assign ss_n = ss_n_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
